// File: rtl/comp_share_precomputer_if.sv
// Sample-in / odd-multiples-out handshake bundle for the
// computation-sharing precomputer bank.
interface comp_share_precomputer_if #(
  parameter int IN_DATA_WIDTH  = 17,
  parameter int OUT_DATA_WIDTH = 21
);
  logic                      in_data_vld;
  logic [IN_DATA_WIDTH-1:0]  in_data;
  logic                      in_data_rdy;
  logic                      out_data_rdy;
  logic                      out_data_vld;
  logic [IN_DATA_WIDTH-1:0]  out_sample;
  logic [OUT_DATA_WIDTH-1:0] x1;
  logic [OUT_DATA_WIDTH-1:0] x3;
  logic [OUT_DATA_WIDTH-1:0] x5;
  logic [OUT_DATA_WIDTH-1:0] x7;
  logic [OUT_DATA_WIDTH-1:0] x9;
  logic [OUT_DATA_WIDTH-1:0] x11;
  logic [OUT_DATA_WIDTH-1:0] x13;
  logic [OUT_DATA_WIDTH-1:0] x15;

  modport master (
    output in_data_vld,
    output in_data,
    output out_data_rdy,
    input  in_data_rdy,
    input  out_data_vld,
    input  out_sample,
    input  x1,
    input  x3,
    input  x5,
    input  x7,
    input  x9,
    input  x11,
    input  x13,
    input  x15
  );

  modport slave (
    input  in_data_vld,
    input  in_data,
    input  out_data_rdy,
    output in_data_rdy,
    output out_data_vld,
    output out_sample,
    output x1,
    output x3,
    output x5,
    output x7,
    output x9,
    output x11,
    output x13,
    output x15
  );
endinterface

// File: rtl/comp_share_precomputer.sv
// Two-stage shift-add precomputer producing x1..x15 odd
// multiples of each sample, with valid/ready flow control.
module comp_share_precomputer #(
  parameter int IN_DATA_WIDTH  = 17,
  parameter int OUT_DATA_WIDTH = 21
) (
  input  logic                    clk,
  input  logic                    reset,
  comp_share_precomputer_if.slave bus
);

  localparam int IW = IN_DATA_WIDTH;
  localparam int OW = OUT_DATA_WIDTH;

  typedef struct packed {
    logic [OW-1:0] x1;
    logic [OW-1:0] x3;
    logic [OW-1:0] x5;
    logic [OW-1:0] x7;
    logic [OW-1:0] x8;
    logic [OW-1:0] x9;
    logic [OW-1:0] x15;
    logic [IW-1:0] smp;
  } s1_t;

  typedef struct packed {
    logic [OW-1:0] x1;
    logic [OW-1:0] x3;
    logic [OW-1:0] x5;
    logic [OW-1:0] x7;
    logic [OW-1:0] x9;
    logic [OW-1:0] x11;
    logic [OW-1:0] x13;
    logic [OW-1:0] x15;
    logic [IW-1:0] smp;
  } s2_t;

  logic          v1;
  logic          v2;
  logic          s1_load;
  logic          s2_load;
  logic          in_xfer;
  logic [OW-1:0] ext;
  s1_t           s1_q;
  s1_t           s1_d;
  s2_t           s2_q;
  s2_t           s2_d;

  // S2 frees up whenever it is empty or being drained
  always_comb begin
    s2_load = !v2 || bus.out_data_rdy;
    s1_load = !v1 || s2_load;
    in_xfer = bus.in_data_vld && bus.in_data_rdy;
  end

  assign bus.in_data_rdy = reset && s1_load;

  assign ext = OW'(bus.in_data);

  always_comb begin
    s1_d     = '0;
    s1_d.x1  = ext;
    s1_d.x3  = (ext << 1) + ext;
    s1_d.x5  = (ext << 2) + ext;
    s1_d.x8  = ext << 3;
    s1_d.x9  = (ext << 3) + ext;
    s1_d.x7  = (ext << 3) - ext;
    s1_d.x15 = (ext << 4) - ext;
    s1_d.smp = bus.in_data;
  end

  always_comb begin
    s2_d     = '0;
    s2_d.x1  = s1_q.x1;
    s2_d.x3  = s1_q.x3;
    s2_d.x5  = s1_q.x5;
    s2_d.x7  = s1_q.x7;
    s2_d.x9  = s1_q.x9;
    s2_d.x11 = s1_q.x8 + s1_q.x3;
    s2_d.x13 = s1_q.x8 + s1_q.x5;
    s2_d.x15 = s1_q.x15;
    s2_d.smp = s1_q.smp;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (s2_load) v2 <= v1;
      if (s1_load) v1 <= in_xfer;
      if (in_xfer) s1_q <= s1_d;
      // bubbles leave S2 data untouched; only vld matters
      if (s2_load && v1) s2_q <= s2_d;
    end
  end

  assign bus.out_data_vld = v2;
  assign bus.out_sample   = s2_q.smp;
  assign bus.x1           = s2_q.x1;
  assign bus.x3           = s2_q.x3;
  assign bus.x5           = s2_q.x5;
  assign bus.x7           = s2_q.x7;
  assign bus.x9           = s2_q.x9;
  assign bus.x11          = s2_q.x11;
  assign bus.x13          = s2_q.x13;
  assign bus.x15          = s2_q.x15;

endmodule
